// File: rtl/toy_pkg.sv
// Shared definitions for the TOY multi-cycle core: opcode map, control states
// and the helper that tells which opcodes touch data memory.
package toy_pkg;

   localparam int unsigned OPCODE_W = 4;

   localparam logic [OPCODE_W-1:0] OP_NOP = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_LDA = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_STA = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_ADD = 4'h3;
   localparam logic [OPCODE_W-1:0] OP_SUB = 4'h4;
   localparam logic [OPCODE_W-1:0] OP_AND = 4'h5;
   localparam logic [OPCODE_W-1:0] OP_OR  = 4'h6;
   localparam logic [OPCODE_W-1:0] OP_XOR = 4'h7;
   localparam logic [OPCODE_W-1:0] OP_NOT = 4'h8;
   localparam logic [OPCODE_W-1:0] OP_LDI = 4'h9;
   localparam logic [OPCODE_W-1:0] OP_JMP = 4'hA;
   localparam logic [OPCODE_W-1:0] OP_JZ  = 4'hB;
   localparam logic [OPCODE_W-1:0] OP_JN  = 4'hC;
   localparam logic [OPCODE_W-1:0] OP_LDX = 4'hD;
   localparam logic [OPCODE_W-1:0] OP_STX = 4'hE;
   localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      MEM    = 3'd2,
      EXEC   = 3'd3,
      HALT   = 3'd4
   } state_t;

   // True for opcodes that need a data-memory transaction before EXEC.
   function automatic logic needs_mem(input logic [OPCODE_W-1:0] op);
      case (op)
         OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND,
         OP_OR, OP_XOR, OP_LDX, OP_STX: needs_mem = 1'b1;
         default:                       needs_mem = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/toy_alu.sv
// Combinational accumulator ALU: ADD/SUB/AND/OR/XOR/NOT on (a, b);
// every other opcode passes b through (used by LDA/LDX/LDI).
module toy_alu
   import toy_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  logic [OPCODE_W-1:0] i_op,
   input  logic [DATA_W-1:0]   i_a,
   input  logic [DATA_W-1:0]   i_b,
   output logic [DATA_W-1:0]   o_y_c
);

   always_comb begin
      o_y_c = i_b;
      case (i_op)
         OP_ADD:  o_y_c = i_a + i_b;
         OP_SUB:  o_y_c = i_a - i_b;
         OP_AND:  o_y_c = i_a & i_b;
         OP_OR:   o_y_c = i_a | i_b;
         OP_XOR:  o_y_c = i_a ^ i_b;
         OP_NOT:  o_y_c = ~i_a;
         default: o_y_c = i_b;
      endcase
   end

endmodule

// File: rtl/toy_mc_core.sv
// Multi-cycle TOY accumulator core sharing one req/ready memory port for
// instructions and data. Define TOY_STEP_EN to add single-step control.
module toy_mc_core
   import toy_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 12,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              reset,
`ifdef TOY_STEP_EN
   input  logic              step,
`endif
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] pc_out,
   output logic [DATA_W-1:0] reg_a_out,
   output logic [DATA_W-1:0] reg_t_out,
   output logic              halted
);

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
   logic [DATA_W-1:0]   r_a, w_a_nxt;
   logic [DATA_W-1:0]   r_t, w_t_nxt;
   logic [DATA_W-1:0]   r_ir, w_ir_nxt;
   logic [DATA_W-1:0]   r_mdr, w_mdr_nxt;
   logic                r_mem_req, w_mem_req_nxt;
   logic                r_mem_we, w_mem_we_nxt;
   logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
   logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
   logic                r_halted, w_halted_nxt;

   logic [OPCODE_W-1:0] w_opcode;
   logic [ADDR_W-1:0]   w_opnd;
   logic                w_indirect;
   logic                w_step_go;
   logic [DATA_W-1:0]   w_alu_b;
   logic [DATA_W-1:0]   w_alu_y;
   logic                w_ir_unused;

`ifdef TOY_STEP_EN
   localparam bit STEP_EN = 1'b1;
   assign w_step_go = step;
`else
   localparam bit STEP_EN = 1'b0;
   assign w_step_go = 1'b1;
`endif

   assign w_opcode    = r_ir[DATA_W-1 -: OPCODE_W];
   assign w_opnd      = r_ir[ADDR_W-1:0];
   assign w_ir_unused = ^r_ir;
   assign w_indirect  = (w_opcode == OP_LDX) || (w_opcode == OP_STX);
   assign w_alu_b     = (w_opcode == OP_LDI) ? DATA_W'(w_opnd) : r_mdr;

   toy_alu #(.DATA_W(DATA_W)) u_alu (
      .i_op  (w_opcode),
      .i_a   (r_a),
      .i_b   (w_alu_b),
      .o_y_c (w_alu_y)
   );

   // Next-state and register-update logic; the memory port is driven from
   // registers so each transaction's request is set up one state ahead.
   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_a_nxt         = r_a;
      w_t_nxt         = r_t;
      w_ir_nxt        = r_ir;
      w_mdr_nxt       = r_mdr;
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_halted_nxt    = r_halted;

      case (r_state)
         FETCH: begin
            if (r_mem_req) begin
               if (mem_ready) begin
                  w_ir_nxt      = mem_rdata;
                  w_pc_nxt      = r_pc + ADDR_W'(1);
                  w_mem_req_nxt = 1'b0;
                  w_state_nxt   = DECODE;
               end
            end else if (w_step_go) begin
               w_mem_req_nxt  = 1'b1;
               w_mem_we_nxt   = 1'b0;
               w_mem_addr_nxt = r_pc;
            end
         end
         DECODE: begin
            if (w_opcode == OP_HLT) begin
               w_halted_nxt = 1'b1;
               w_state_nxt  = HALT;
            end else if (needs_mem(w_opcode)) begin
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = (w_opcode == OP_STA) || (w_opcode == OP_STX);
               w_mem_addr_nxt  = w_indirect ? r_a[ADDR_W-1:0] : w_opnd;
               w_mem_wdata_nxt = (w_opcode == OP_STX) ? r_t : r_a;
               w_state_nxt     = MEM;
            end else begin
               w_state_nxt = EXEC;
            end
         end
         MEM: begin
            if (r_mem_req && mem_ready) begin
               w_mdr_nxt     = mem_rdata;
               w_mem_req_nxt = 1'b0;
               w_mem_we_nxt  = 1'b0;
               w_state_nxt   = EXEC;
            end
         end
         EXEC: begin
            case (w_opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR,
               OP_XOR, OP_NOT, OP_LDI, OP_LDX: begin
                  w_t_nxt = r_a;
                  w_a_nxt = w_alu_y;
               end
               OP_JMP: w_pc_nxt = w_opnd;
               OP_JZ:  if (r_a == '0) w_pc_nxt = w_opnd;
               OP_JN:  if (r_a[DATA_W-1]) w_pc_nxt = w_opnd;
               default: ;
            endcase
            w_state_nxt = FETCH;
            // Free-running build requests the next fetch straight away.
            if (!STEP_EN) begin
               w_mem_req_nxt  = 1'b1;
               w_mem_we_nxt   = 1'b0;
               w_mem_addr_nxt = w_pc_nxt;
            end
         end
         HALT: begin
            w_mem_req_nxt = 1'b0;
            w_halted_nxt  = 1'b1;
         end
         default: begin
            w_mem_req_nxt = 1'b0;
            w_mem_we_nxt  = 1'b0;
            w_state_nxt   = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= FETCH;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc        <= ADDR_W'(RESET_PC);
         r_a         <= '0;
         r_t         <= '0;
         r_ir        <= '0;
         r_mdr       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_halted    <= 1'b0;
      end else begin
         r_pc        <= w_pc_nxt;
         r_a         <= w_a_nxt;
         r_t         <= w_t_nxt;
         r_ir        <= w_ir_nxt;
         r_mdr       <= w_mdr_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_we    <= w_mem_we_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_halted    <= w_halted_nxt;
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign pc_out    = r_pc;
   assign reg_a_out = r_a;
   assign reg_t_out = r_t;
   assign halted    = r_halted;

endmodule

// File: tb/tb_toy_mc_core.sv
// Self-checking bench for toy_mc_core: wait-state memory, instruction-level
// reference model, directed programs and random programs.
module tb_toy_mc_core;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 12;
`ifdef TOY_STEP_EN
   localparam int STEP_EXTRA = 1;
`else
   localparam int STEP_EXTRA = 0;
`endif

   typedef struct packed {
      logic        we;
      logic [11:0] addr;
      logic [15:0] data;
   } txn_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              mem_ready = 1'b0;
   logic [ADDR_W-1:0] pc_out;
   logic [DATA_W-1:0] reg_a_out, reg_t_out;
   logic              halted;
`ifdef TOY_STEP_EN
   logic              step = 1'b1;
`endif

   logic [15:0] mem  [0:4095];
   logic [15:0] mmem [0:4095];
   txn_t act_q[$];
   txn_t exp_q[$];

   int   wait_states = 0;
   int   wcnt = 0, cyc = 0, first_req = -1, halt_cyc = -1;
   int   unstable = 0, b2b = 0;
   logic prev_req = 1'b0, prev_done = 1'b0;
   txn_t prev_t;

   int   n_checks = 0, n_pass = 0;
   int   model_w, exp_cycles;
   logic [15:0] exp_a, exp_t;
   logic [11:0] exp_pc;
   int   last_cycles;

   toy_mc_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(0)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef TOY_STEP_EN
      .step      (step),
`endif
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc_out    (pc_out),
      .reg_a_out (reg_a_out),
      .reg_t_out (reg_t_out),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   // Memory responder and bus monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (reset) begin
         mem_ready = 1'b0;
         wcnt = 0; cyc = 0; first_req = -1; halt_cyc = -1;
         unstable = 0; b2b = 0; prev_req = 1'b0; prev_done = 1'b0;
         act_q.delete();
      end else begin
         cyc++;
         if (mem_req && first_req < 0) first_req = cyc;
         if (halted && halt_cyc < 0) halt_cyc = cyc;
         if (mem_req) begin
            if (prev_done) b2b++;
            if (prev_req && !prev_done &&
                (mem_we !== prev_t.we || mem_addr !== prev_t.addr ||
                 (mem_we && mem_wdata !== prev_t.data)))
               unstable++;
            prev_t = '{mem_we, mem_addr, mem_wdata};
            if (wcnt < wait_states) begin
               mem_ready = 1'b0;
               wcnt++;
               prev_done = 1'b0;
            end else begin
               mem_ready = 1'b1;
               wcnt = 0;
               prev_done = 1'b1;
               act_q.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : 16'h0});
               if (mem_we) mem[mem_addr] = mem_wdata;
            end
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
            prev_done = 1'b0;
         end
         prev_req = mem_req;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Instruction-level reference: one ISA step per loop iteration.
   task automatic m_read(input logic [11:0] addr, output logic [15:0] v);
      exp_q.push_back('{1'b0, addr, 16'h0});
      exp_cycles += model_w;
      v = mmem[addr];
   endtask

   task automatic m_write(input logic [11:0] addr, input logic [15:0] v);
      exp_q.push_back('{1'b1, addr, v});
      exp_cycles += model_w;
      mmem[addr] = v;
   endtask

   task automatic model_run(output logic ok);
      logic [11:0] pc, opnd;
      logic [15:0] a, t, ir, v;
      logic [3:0]  op;
      pc = 12'h000; a = 16'h0; t = 16'h0; ok = 1'b0;
      exp_q.delete(); exp_cycles = 0;
      for (int n = 0; n < 300 && !ok; n++) begin
         m_read(pc, ir);
         if (n > 0) exp_cycles += STEP_EXTRA;
         pc = pc + 12'h1;
         op = ir[15:12];
         opnd = ir[11:0];
         case (op)
            4'h0: exp_cycles += 3;
            4'h1: begin m_read(opnd, v); t = a; a = v;     exp_cycles += 4; end
            4'h2: begin m_write(opnd, a);                  exp_cycles += 4; end
            4'h3: begin m_read(opnd, v); t = a; a = a + v; exp_cycles += 4; end
            4'h4: begin m_read(opnd, v); t = a; a = a - v; exp_cycles += 4; end
            4'h5: begin m_read(opnd, v); t = a; a = a & v; exp_cycles += 4; end
            4'h6: begin m_read(opnd, v); t = a; a = a | v; exp_cycles += 4; end
            4'h7: begin m_read(opnd, v); t = a; a = a ^ v; exp_cycles += 4; end
            4'h8: begin t = a; a = ~a;                     exp_cycles += 3; end
            4'h9: begin t = a; a = {4'h0, opnd};           exp_cycles += 3; end
            4'hA: begin pc = opnd;                         exp_cycles += 3; end
            4'hB: begin if (a == 16'h0) pc = opnd;         exp_cycles += 3; end
            4'hC: begin if (a[15]) pc = opnd;              exp_cycles += 3; end
            4'hD: begin m_read(a[11:0], v); t = a; a = v;  exp_cycles += 4; end
            4'hE: begin m_write(a[11:0], t);               exp_cycles += 4; end
            default: begin ok = 1'b1;                      exp_cycles += 2; end
         endcase
      end
      exp_a = a; exp_t = t; exp_pc = pc;
   endtask

   task automatic fill_mem(input logic [15:0] v);
      for (int i = 0; i < 4096; i++) mem[i] = v;
   endtask

   task automatic pulse_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
   endtask

   // Run the program in mem to HALT and compare everything with the model.
   task automatic run_prog(input string tag, input int w);
      logic mok;
      int   budget, n0, bad;
      for (int i = 0; i < 4096; i++) mmem[i] = mem[i];
      model_w = w;
      model_run(mok);
      budget = mok ? exp_cycles + 100 : 4000;
      wait_states = w;
      pulse_reset();
      @(posedge clk); #1;
      check({tag, ":first_req"}, 32'(mem_req), 32'h1);
      check({tag, ":first_addr"}, 32'(mem_addr), 32'h0);
      for (int i = 0; i < budget && halted !== 1'b1; i++) @(negedge clk);
      check({tag, ":halted"}, 32'(halted), 32'h1);
      n0 = act_q.size();
      repeat (3) @(negedge clk);
      check({tag, ":no_req_in_halt"}, 32'(act_q.size()), 32'(n0));
      check({tag, ":req_low"}, 32'(mem_req), 32'h0);
      check({tag, ":pc"}, 32'(pc_out), 32'(exp_pc));
      check({tag, ":a"}, 32'(reg_a_out), 32'(exp_a));
      check({tag, ":t"}, 32'(reg_t_out), 32'(exp_t));
      last_cycles = halt_cyc - first_req;
      check({tag, ":cycles"}, 32'(last_cycles), 32'(exp_cycles));
      check({tag, ":txn_count"}, 32'(act_q.size()), 32'(exp_q.size()));
      bad = -1;
      for (int i = 0; i < act_q.size() && i < exp_q.size() && bad < 0; i++)
         if (act_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0)
         $display("%s: txn %0d observed=%h expected=%h", tag, bad, act_q[bad], exp_q[bad]);
      check({tag, ":txn_seq_first_bad"}, 32'(bad), 32'hFFFF_FFFF);
      check({tag, ":bus_stable"}, 32'(unstable), 32'h0);
      check({tag, ":req_gap"}, 32'(b2b), 32'h0);
   endtask

   task automatic gen_random();
      logic [3:0]  op;
      logic [11:0] opnd;
      logic        mok;
      for (int tries = 0; tries < 20; tries++) begin
         fill_mem(16'hF000);
         for (int i = 12'h100; i < 12'h110; i++) mem[i] = 16'($urandom);
         for (int pc = 0; pc < 20; pc++) begin
            op = 4'($urandom_range(0, 14));
            if (op >= 4'h1 && op <= 4'h7)
               opnd = 12'(12'h100 + $urandom_range(0, 15));
            else if (op >= 4'hA && op <= 4'hC)
               opnd = 12'(pc + 1 + $urandom_range(0, 3));
            else if (op == 4'h9 && $urandom_range(0, 1) == 1)
               opnd = 12'(12'h100 + $urandom_range(0, 15));
            else
               opnd = 12'($urandom);
            mem[pc] = {op, opnd};
         end
         for (int i = 0; i < 4096; i++) mmem[i] = mem[i];
         model_w = 0;
         model_run(mok);
         if (mok) break;
      end
   endtask

   initial begin
      int cnt;
      fill_mem(16'hF000);

      // Reset values while reset is held.
      repeat (2) @(negedge clk);
      check("rst:mem_req", 32'(mem_req), 32'h0);
      check("rst:mem_we", 32'(mem_we), 32'h0);
      check("rst:mem_addr", 32'(mem_addr), 32'h0);
      check("rst:mem_wdata", 32'(mem_wdata), 32'h0);
      check("rst:pc", 32'(pc_out), 32'h0);
      check("rst:a", 32'(reg_a_out), 32'h0);
      check("rst:t", 32'(reg_t_out), 32'h0);
      check("rst:halted", 32'(halted), 32'h0);

      // HLT at address 0.
      run_prog("hlt0", 0);
      check("hlt0:pc_const", 32'(pc_out), 32'h1);

      // Load and add with wrap, then the same with wait states.
      fill_mem(16'hF000);
      mem[0] = 16'h1010; mem[1] = 16'h3011; mem[2] = 16'hF000;
      mem[12'h010] = 16'h0005; mem[12'h011] = 16'hFFFE;
      run_prog("ldadd", 0);
      check("ldadd:a_const", 32'(reg_a_out), 32'h0003);
      check("ldadd:t_const", 32'(reg_t_out), 32'h0005);
      check("ldadd:cycles_const", 32'(last_cycles), 32'(10 + 2 * STEP_EXTRA));
      run_prog("ldadd_w3", 3);
      check("ldadd_w3:a_const", 32'(reg_a_out), 32'h0003);
      check("ldadd_w3:cycles_const", 32'(last_cycles), 32'(25 + 2 * STEP_EXTRA));

      // JZ taken over address 2.
      fill_mem(16'hF000);
      mem[0] = 16'h9000; mem[1] = 16'hB005; mem[2] = 16'h9001;
      run_prog("jz", 1);
      check("jz:pc_const", 32'(pc_out), 32'h6);
      cnt = 0;
      foreach (act_q[i]) if (!act_q[i].we && act_q[i].addr == 12'h002) cnt++;
      check("jz:addr2_fetches", 32'(cnt), 32'h0);

      // JN not taken on 0x7FFF.
      fill_mem(16'hF000);
      mem[0] = 16'h1010; mem[1] = 16'hC005; mem[12'h010] = 16'h7FFF;
      run_prog("jn", 0);
      check("jn:pc_const", 32'(pc_out), 32'h3);
      check("jn:a_const", 32'(reg_a_out), 32'h7FFF);

      // Indirect store writes old A (in T) to address in A.
      fill_mem(16'hF000);
      mem[0] = 16'h9020; mem[1] = 16'h9030; mem[2] = 16'hE000;
      run_prog("stx", 2);
      cnt = 0;
      foreach (act_q[i]) if (act_q[i].we && act_q[i].addr == 12'h030 && act_q[i].data == 16'h0020) cnt++;
      check("stx:write_seen", 32'(cnt), 32'h1);

      // Random programs against the reference model.
      for (int k = 0; k < 8; k++) begin
         gen_random();
         run_prog($sformatf("rnd%0d", k), $urandom_range(0, 3));
      end

      // PC wrap through 0xFFF, then asynchronous reset mid-transaction.
      fill_mem(16'hF000);
      mem[0] = 16'hAFFF; mem[12'hFFF] = 16'h0000;
      wait_states = 2;
      pulse_reset();
      for (int i = 0; i < 100 && act_q.size() < 3; i++) @(negedge clk);
      check("wrap:txn_count", 32'(act_q.size() >= 3), 32'h1);
      if (act_q.size() >= 3) begin
         check("wrap:second_fetch", 32'({act_q[1].we, act_q[1].addr}), 32'hFFF);
         check("wrap:third_fetch", 32'({act_q[2].we, act_q[2].addr}), 32'h000);
      end
      @(negedge clk);
      for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clk);
      check("midrst:req_before", 32'(mem_req), 32'h1);
      #2 reset = 1'b1;
      #1;
      check("midrst:req", 32'(mem_req), 32'h0);
      check("midrst:pc", 32'(pc_out), 32'h0);
      check("midrst:halted", 32'(halted), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/toy_mc_core.md
Name: toy_mc_core

Overview:
- Parametrised multi-cycle successor to the single-cycle TOY accumulator CPU.
- Register set: PC, accumulator A, shadow T. T always receives the old A whenever A is written.
- Instruction and data share one external memory port with a req/ready handshake, so wait-state memories are supported.
- A control FSM sequences fetch, decode, memory and execute, adds a halt state, and provides a defined opcode map.

Parameters:
- DATA_W, 16, width of A, T and memory words; must be >= ADDR_W+4.
- ADDR_W, 12, width of PC and memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-high reset.
- mem_req, output, 1, memory transaction request.
- mem_we, output, 1, 1 = write, 0 = read.
- mem_addr, output, ADDR_W, transaction address.
- mem_wdata, output, DATA_W, write data.
- mem_rdata, input, DATA_W, read data; valid when mem_ready=1.
- mem_ready, input, 1, transaction completes at the posedge where mem_req and mem_ready are both 1.
- pc_out, output, ADDR_W, current PC.
- reg_a_out, output, DATA_W, current A.
- reg_t_out, output, DATA_W, current T.
- halted, output, 1, core is in HALT.

Behaviour:
- Reset values: PC=RESET_PC, A=0, T=0, IR=0, state=FETCH, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
- Reset is asynchronous. Asserting it mid-transaction drops mem_req immediately and abandons the transaction.
- Instruction format:
  - opcode = IR[DATA_W-1 -: 4]
  - opnd = IR[ADDR_W-1:0]
  - bits between opcode and opnd are ignored.
- FSM states: FETCH, DECODE, MEM, EXEC, HALT.
  - FETCH: mem_req=1, we=0, addr=PC. On ready: IR<=rdata, PC<=PC+1 (wraps mod 2^ADDR_W), go to DECODE.
  - DECODE: go to MEM for LDA/STA/ADD/SUB/AND/OR/XOR/LDX/STX, HALT for HLT, EXEC otherwise.
  - MEM: hold req/we/addr/wdata stable until ready. On ready, latch rdata into MDR, go to EXEC.
  - EXEC: perform the register/PC update, go to FETCH.
  - HALT: absorbing until reset. No mem_req; halted=1.
- Opcodes (A' = new A; every A write also does T<=old A):
  - 0 NOP.
  - 1 LDA: A'=M[opnd].
  - 2 STA: M[opnd]=A.
  - 3 ADD: A'=A+M[opnd].
  - 4 SUB: A'=A-M[opnd].
  - 5 AND, 6 OR, 7 XOR: A' = A op M[opnd].
  - 8 NOT: A'=~A.
  - 9 LDI: A'=zero-extended opnd.
  - A JMP: PC=opnd.
  - B JZ: PC=opnd if A==0.
  - C JN: PC=opnd if A[DATA_W-1]=1.
  - D LDX: A'=M[A[ADDR_W-1:0]].
  - E STX: M[A[ADDR_W-1:0]]=T.
  - F HLT.
- Arithmetic is modulo 2^DATA_W with no flags. Stores (STA, STX) do not modify A or T.
- Latency with ready tied high:
  - memory ops: 4 cycles.
  - NOP/NOT/LDI/jumps: 3 cycles.
  - HLT: 2 cycles to HALT.
  - Each wait cycle of mem_ready adds 1 cycle.
- Between transactions, mem_req deasserts for at least one cycle. No back-to-back transactions.
- Any mem_ready seen while mem_req=0 is ignored.
- Jump conditions are evaluated on A as it stands in EXEC.

Optional Feature:
- Macro: TOY_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - The FSM waits in FETCH with mem_req=0 until step is sampled high, then executes exactly one instruction.
  - A step held high runs one instruction per FETCH entry.
  - step is ignored in HALT.
- When undefined: no step port; the core runs freely.

Decomposition:
- Package toy_pkg holds:
  - opcode localparams OP_NOP..OP_HLT (4-bit);
  - state enum typedef (FETCH, DECODE, MEM, EXEC, HALT);
  - a needs_mem(opcode) function.
- Sub-module toy_alu (combinational):
  - inputs: op, a, b;
  - output: y;
  - covers ADD/SUB/AND/OR/XOR/NOT/pass-b.
- The FSM and registers stay in toy_mc_core.

Test Plan:
- Reset and fetch:
  - reset pulse, ready=1 -> first posedge after release: mem_req=1, mem_addr=0.
  - after HLT at addr 0: halted=1, mem_req stays 0.
- Load and add:
  - M[0]=LDA 0x010, M[1]=ADD 0x011, M[2]=HLT, M[0x10]=0x0005, M[0x11]=0xFFFE, ready=1.
  - Expect A=0x0003 (wraps) and T=0x0005.
  - Expect 10 cycles from reset release to halted: LDA 4, ADD 4, HLT 2.
- Wait states:
  - same program, ready low for 3 cycles per transaction.
  - mem_req/addr stay stable throughout; final A=0x0003; runtime grows by 3 per transaction.
- Branching:
  - LDI 0, JZ 0x005, LDI 1 (at 2), M[5]=HLT.
  - Expect instruction 2 never fetched, PC=6 at halt.
  - JN not taken when A=0x7FFF.
- Indirect store:
  - LDI 0x020, LDI 0x030, STX.
  - Expect a write with mem_addr=0x030, mem_wdata=0x0020.
- PC wrap and mid-operation reset:
  - JMP 0xFFF to a NOP at 0xFFF -> next fetch addr 0x000.
  - reset asserted while mem_req=1 -> mem_req=0 in the same cycle, PC=0.
